rgmii_tx_framer: RTL and testbench
==================================

// Module: rgmii_tx_framer
// PURPOSE
//  Ethernet MAC transmit framer for the RGMII TX path. Accepts a byte stream
//  (valid/ready/last), prepends preamble+SFD, appends CRC32 FCS, enforces the
//  inter-packet gap, and drives a registered 10-bit word to the ODDR pad wrapper.
//  Mirror of the RX capture path: q[4:0] goes out on the first (rising) clk edge,
//  q[9:5] on the second (falling) edge.
// PARAMETERS
//  PREAMBLE_LEN  7   number of 0x55 bytes before SFD (0xD5)
//  IPG_BYTES     12  idle byte-times after FCS or abort before next preamble
//  MIN_FRAME     60  minimum payload bytes before FCS (used only with pad option)
// PORTS
//  clk          in   1   125 MHz byte clock (ODDR clock)
//  rst_n        in   1   asynchronous reset, active low
//  s_data       in   8   payload byte (dest MAC first)
//  s_valid      in   1   s_data valid
//  s_last       in   1   last payload byte of frame, qualified by s_valid
//  s_ready      out  1   byte accepted when s_valid & s_ready
//  q            out  10  {ctl_f, d[7:4], ctl_r, d[3:0]} to ODDR
//  busy         out  1   state != IDLE
//  tx_done      out  1   1-cycle pulse on last FCS byte
//  tx_abort     out  1   1-cycle pulse on underrun abort
//  frame_cnt    out  16  frames completed with FCS; wraps 0xFFFF -> 0
// BEHAVIOUR
//  - Reset (async assert, sync release): state IDLE, q=0, s_ready=0, busy=0,
//    tx_done=0, tx_abort=0, frame_cnt=0, CRC reg=0xFFFFFFFF. Mid-frame reset cuts
//    the frame immediately; q=0 on the next edge, no FCS, no pulse.
//  - Encoding: q[3:0]=byte[3:0], q[4]=tx_en; q[8:5]=byte[7:4], q[9]=tx_en^tx_er.
//    Idle: q=10'h000. Normal byte: q[4]=q[9]=1. Error byte: q[4]=1, q[9]=0.
//  - All outputs registered. s_valid seen in IDLE at edge N -> first preamble
//    byte on q after edge N+1 (1-cycle latency).
//  - FSM: IDLE -> PRE (PREAMBLE_LEN x 0x55) -> SFD (0xD5) -> DATA -> [PAD] ->
//    FCS (4 bytes) -> IPG (IPG_BYTES cycles, q=0) -> IDLE.
//  - s_ready=1 only in DATA (and DRAIN); byte on q the cycle after acceptance.
//  - DATA: s_valid&s_last accepted -> PAD or FCS. Single-byte frames are legal.
//  - Underrun: s_valid=0 in DATA -> ABORT: one error byte (0x00, tx_en=1, tx_er=1),
//    tx_abort pulse, then DRAIN: s_ready=1, discard bytes through s_last, then IPG.
//    frame_cnt is not incremented. If s_last arrives on the abort cycle, go
//    straight to IPG.
//  - CRC32: IEEE reflected, poly 0xEDB88320, init 0xFFFFFFFF, over payload+pad
//    bytes (not preamble/SFD). FCS = ~crc, sent LS byte first.
//  - Byte counter is 16 bits and saturates at 0xFFFF (frames never wrap it).
//  - frame_cnt and tx_done update on the last FCS byte cycle.
//  - s_valid outside DATA/DRAIN is ignored (held off by s_ready=0).
// CONFIGURATION
//  RGMII_TX_PAD_EN defined: if s_last is accepted with count < MIN_FRAME, PAD
//    sends 0x00 bytes (included in CRC) until MIN_FRAME payload bytes have been
//    sent, then FCS.
//  Not defined: no PAD state; frames go out as given (short frames allowed) and
//    DATA -> FCS directly.
// TESTING
//  1. Frame "123456789" (0x31..0x39), PAD off -> q: 7x 0x55, 0xD5, 9 data bytes,
//     FCS 26 39 F4 CB, tx_done, frame_cnt=1; every tx_en byte has q[4]=q[9]=1.
//  2. Two back-to-back 64-byte frames with s_valid held high -> exactly 12
//     idle cycles (q=0) between last FCS byte and next preamble.
//  3. s_valid dropped after byte 5 -> one byte with q[4]=1, q[9]=0, tx_abort
//     pulse, rest drained through s_last, frame_cnt unchanged, then 12 idle.
//  4. rst_n low during DATA byte 20 -> q=0, busy=0, s_ready=0 at once; next frame
//     after release has correct CRC (no stale CRC state).
//  5. RGMII_TX_PAD_EN, 1-byte frame 0xAB -> 0xAB + 59x 0x00 + 4 FCS bytes
//     matching a reference CRC over 60 bytes; without the macro -> 1 + 4 bytes.
//  6. frame_cnt preloaded by forcing to 0xFFFF, one good frame sent -> 0x0000.

Source files
------------

// File: rtl/rgmii_tx_framer.sv
// RGMII transmit framer: preamble/SFD insertion, CRC32 FCS, underrun abort and inter-packet gap.
// Define RGMII_TX_PAD_EN to zero-pad short frames up to MIN_FRAME payload bytes.
module rgmii_tx_framer #(
  parameter int PREAMBLE_LEN = 7,
  parameter int IPG_BYTES    = 12
`ifdef RGMII_TX_PAD_EN
  , parameter int MIN_FRAME  = 60
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [9:0]  q,
  output logic        busy,
  output logic        tx_done,
  output logic        tx_abort,
  output logic [15:0] frame_cnt
);

  typedef enum logic [3:0] {
    IDLE, PRE, SFD, DATA,
`ifdef RGMII_TX_PAD_EN
    PAD,
`endif
    FCS, ABORT, DRAIN, IPG
  } state_t;

  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] IPG_LAST = 16'(IPG_BYTES - 1);
`ifdef RGMII_TX_PAD_EN
  localparam logic [15:0] MIN_CNT  = 16'(MIN_FRAME);
`endif

  // Data byte as a 10-bit ODDR word with tx_en=1; er flips the falling-edge ctl bit.
  function automatic logic [9:0] enc(input logic [7:0] b, input logic er);
    return {~er, b[7:4], 1'b1, b[3:0]};
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    return c;
  endfunction

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next, cnt_inc;
  logic [31:0] crc, crc_next, fcs;
  logic [9:0]  q_next;
  logic        tx_done_next, tx_abort_next;

  assign cnt_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  assign fcs     = ~crc;

  // NOTE: every signal written here gets a default first so no path can infer a latch.
  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    crc_next      = crc;
    q_next        = '0;
    tx_done_next  = 1'b0;
    tx_abort_next = 1'b0;
    case (state)
      IDLE: if (s_valid) begin
        state_next = PRE;
        cnt_next   = '0;
      end
      PRE: begin
        q_next = enc(8'h55, 1'b0);
        if (cnt == PRE_LAST) state_next = SFD;
        else                 cnt_next   = cnt + 16'd1;
      end
      SFD: begin
        q_next     = enc(8'hD5, 1'b0);
        crc_next   = CRC_INIT;
        cnt_next   = '0;
        state_next = DATA;
      end
      DATA: begin
        if (s_valid) begin
          q_next   = enc(s_data, 1'b0);
          crc_next = crc_byte(crc, s_data);
          cnt_next = cnt_inc;
          if (s_last) begin
`ifdef RGMII_TX_PAD_EN
            if (cnt_inc < MIN_CNT) begin
              state_next = PAD;
            end else begin
              state_next = FCS;
              cnt_next   = '0;
            end
`else
            state_next = FCS;
            cnt_next   = '0;
`endif
          end
        end else begin
          q_next        = enc(8'h00, 1'b1);
          tx_abort_next = 1'b1;
          state_next    = ABORT;
        end
      end
`ifdef RGMII_TX_PAD_EN
      PAD: begin
        q_next   = enc(8'h00, 1'b0);
        crc_next = crc_byte(crc, 8'h00);
        if (cnt_inc >= MIN_CNT) begin
          state_next = FCS;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
`endif
      FCS: begin
        q_next = enc(fcs[{cnt[1:0], 3'b000} +: 8], 1'b0);
        if (cnt[1:0] == 2'd3) begin
          tx_done_next = 1'b1;
          state_next   = IPG;
          cnt_next     = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      // ABORT is the first discard cycle: the error byte is already on q and a byte may be taken.
      ABORT, DRAIN: begin
        if (s_valid && s_last) begin
          state_next = IPG;
          cnt_next   = '0;
        end else begin
          state_next = DRAIN;
        end
      end
      IPG: begin
        if (cnt == IPG_LAST) begin
          state_next = s_valid ? PRE : IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      crc       <= CRC_INIT;
      q         <= '0;
      s_ready   <= 1'b0;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
      tx_abort  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      crc      <= crc_next;
      q        <= q_next;
      s_ready  <= (state_next == DATA) || (state_next == ABORT) || (state_next == DRAIN);
      busy     <= (state_next != IDLE);
      tx_done  <= tx_done_next;
      tx_abort <= tx_abort_next;
      if (tx_done_next) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_framer.sv
// Directed self-checking bench for rgmii_tx_framer; expected words come from hand values
// and an independent bit-serial CRC32 reference.
module tb_rgmii_tx_framer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid, s_last;
  logic        s_ready;
  logic [9:0]  q;
  logic        busy, tx_done, tx_abort;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_frames = '0;

  logic [9:0] q_log[$];
  logic       done_log[$];
  logic       abort_log[$];
  logic [8:0] stim_q[$];
  logic [9:0] exp_q[$];

  rgmii_tx_framer dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .q(q), .busy(busy), .tx_done(tx_done), .tx_abort(tx_abort),
    .frame_cnt(frame_cnt)
  );

  always #4 clk = ~clk;

  function automatic logic [9:0] enc(input logic [7:0] b);
    return {1'b1, b[7:4], 1'b1, b[3:0]};
  endfunction

  function automatic logic [31:0] ref_fcs(input logic [7:0] p[$]);
    logic [31:0] c;
    logic fb;
    c = 32'hFFFF_FFFF;
    foreach (p[k])
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ p[k][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    return ~c;
  endfunction

  function automatic void build_exp(input logic [7:0] p[$]);
    logic [31:0] fcs;
    fcs = ref_fcs(p);
    exp_q.delete();
    for (int i = 0; i < 7; i++) exp_q.push_back(enc(8'h55));
    exp_q.push_back(enc(8'hD5));
    foreach (p[k]) exp_q.push_back(enc(p[k]));
    for (int i = 0; i < 4; i++) exp_q.push_back(enc(fcs[8*i +: 8]));
  endfunction

  function automatic void add_frame(input logic [7:0] p[$]);
    foreach (p[k]) stim_q.push_back({k == p.size() - 1, p[k]});
  endfunction

  function automatic int first_active(input int from);
    for (int i = from; i < q_log.size(); i++) if (q_log[i][4]) return i;
    return -1;
  endfunction

  function automatic int first_done(input int from);
    for (int i = from; i < done_log.size(); i++) if (done_log[i]) return i;
    return -1;
  endfunction

  // Streams stim onto the input handshake for ncycles, logging outputs at each falling edge.
  // drop_at >= 0 withholds s_valid for one cycle once that many bytes have been accepted.
  task automatic drive(input logic [8:0] stim[$], input int drop_at, input int ncycles);
    int idx;
    bit dropped;
    logic prev_ready;
    idx = 0;
    dropped = 0;
    q_log.delete(); done_log.delete(); abort_log.delete();
    s_valid = 1'b1; s_data = stim[0][7:0]; s_last = stim[0][8];
    prev_ready = s_ready;
    for (int i = 0; i < ncycles; i++) begin
      @(negedge clk);
      q_log.push_back(q); done_log.push_back(tx_done); abort_log.push_back(tx_abort);
      if (s_valid && prev_ready) idx++;
      prev_ready = s_ready;
      if (idx == drop_at && !dropped) begin
        s_valid = 1'b0; dropped = 1;
      end else if (idx < stim.size()) begin
        s_valid = 1'b1; s_data = stim[idx][7:0]; s_last = stim[idx][8];
      end else begin
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      end
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({q, s_ready, busy, tx_done, tx_abort, frame_cnt} !== 30'h0) begin
      errors++;
      $display("FAIL reset_outputs q=%h rdy=%b busy=%b done=%b abort=%b cnt=%h want all zero",
               q, s_ready, busy, tx_done, tx_abort, frame_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (q !== 10'h000 || busy !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset q=%h busy=%b want 000/0", q, busy);
    end
  endtask

  task automatic test_basic_frame();
    logic [7:0] want[$];
    int f;
    stim_q.delete();
    add_frame('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39});
    drive(stim_q, -1, 40);
    for (int i = 0; i < 7; i++) want.push_back(8'h55);
    want.push_back(8'hD5);
    for (int i = 0; i < 9; i++) want.push_back(8'h31 + 8'(i));
    want.push_back(8'h26); want.push_back(8'h39); want.push_back(8'hF4); want.push_back(8'hCB);
    f = first_active(0);
    checks++;
    if (f !== 1) begin errors++; $display("FAIL start_latency got=%0d want=1", f); end
    if (f < 0) f = 0;
    foreach (want[i]) begin
      checks++;
      if (q_log[f+i] !== enc(want[i])) begin
        errors++; $display("FAIL basic_word%0d got=%h want=%h", i, q_log[f+i], enc(want[i]));
      end
    end
    checks++;
    if (first_done(0) !== f + 20) begin
      errors++; $display("FAIL basic_done_pos got=%0d want=%0d", first_done(0), f + 20);
    end
    checks++;
    if (q_log[f+21] !== 10'h000) begin
      errors++; $display("FAIL basic_idle_after got=%h want=000", q_log[f+21]);
    end
    exp_frames++;
    checks++;
    if (frame_cnt !== exp_frames) begin
      errors++; $display("FAIL basic_frame_cnt got=%h want=%h", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] p1[$], p2[$];
    logic [9:0] e1[$];
    int f1, d1, f2, d2, n;
    for (int i = 0; i < 64; i++) begin p1.push_back(8'(i)); p2.push_back(8'hFF - 8'(i)); end
    stim_q.delete(); add_frame(p1); add_frame(p2);
    drive(stim_q, -1, 190);
    build_exp(p1); e1 = exp_q;
    f1 = first_active(0);
    d1 = first_done(0);
    checks++;
    if (f1 !== 1 || d1 !== f1 + 75) begin
      errors++; $display("FAIL b2b_first_frame start=%0d done=%0d want 1/76", f1, d1);
    end
    n = 0;
    if (f1 < 0) n = 1; else foreach (e1[i]) if (q_log[f1+i] !== e1[i]) n++;
    checks++;
    if (n != 0) begin errors++; $display("FAIL b2b_frame1_words bad=%0d want 0", n); end
    f2 = (d1 < 0) ? -1 : first_active(d1 + 1);
    checks++;
    if (f2 - d1 - 1 !== 12) begin
      errors++; $display("FAIL b2b_ipg idle=%0d want 12", f2 - d1 - 1);
    end
    build_exp(p2);
    n = 0;
    if (f2 < 0) n = 1; else foreach (exp_q[i]) if (q_log[f2+i] !== exp_q[i]) n++;
    checks++;
    if (n != 0) begin errors++; $display("FAIL b2b_frame2_words bad=%0d want 0", n); end
    d2 = (f2 < 0) ? -1 : first_done(f2);
    checks++;
    if (d2 !== f2 + 75) begin errors++; $display("FAIL b2b_done2_pos got=%0d want=%0d", d2, f2 + 75); end
    exp_frames += 2;
    checks++;
    if (frame_cnt !== exp_frames) begin
      errors++; $display("FAIL b2b_frame_cnt got=%h want=%h", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] pa[$], pb[$];
    int f, a, fb, n, n_abort, n_done;
    for (int i = 0; i < 12; i++) pa.push_back(8'h40 + 8'(i));
    pb = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    stim_q.delete(); add_frame(pa); add_frame(pb);
    drive(stim_q, 5, 70);
    build_exp(pa);
    f = first_active(0);
    n = 0;
    if (f < 0) n = 1; else for (int i = 0; i < 13; i++) if (q_log[f+i] !== exp_q[i]) n++;
    checks++;
    if (n != 0) begin errors++; $display("FAIL abort_head_words bad=%0d want 0", n); end
    a = (f < 0) ? 0 : f + 13;
    checks++;
    if (q_log[a] !== 10'h010 || abort_log[a] !== 1'b1) begin
      errors++; $display("FAIL abort_error_byte q=%h pulse=%b want 010/1", q_log[a], abort_log[a]);
    end
    n_abort = 0; n_done = 0;
    foreach (abort_log[i]) n_abort += int'(abort_log[i]);
    foreach (done_log[i]) n_done += int'(done_log[i]);
    checks++;
    if (n_abort != 1 || n_done != 1) begin
      errors++; $display("FAIL abort_pulse_counts abort=%0d done=%0d want 1/1", n_abort, n_done);
    end
    fb = first_active(a + 1);
    checks++;
    if (fb !== a + 20) begin
      errors++; $display("FAIL abort_drain_ipg next_start=%0d want=%0d", fb, a + 20);
    end
    build_exp(pb);
    n = 0;
    if (fb < 0) n = 1; else foreach (exp_q[i]) if (q_log[fb+i] !== exp_q[i]) n++;
    checks++;
    if (n != 0) begin errors++; $display("FAIL abort_next_frame_words bad=%0d want 0", n); end
    exp_frames++;
    checks++;
    if (frame_cnt !== exp_frames) begin
      errors++; $display("FAIL abort_frame_cnt got=%h want=%h", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] p[$];
    int f, n;
    for (int i = 0; i < 40; i++) p.push_back(8'(3 * i + 1));
    stim_q.delete(); add_frame(p);
    drive(stim_q, -1, 30);
    checks++;
    if (q_log[29] !== enc(p[20])) begin
      errors++; $display("FAIL rst_in_data got=%h want=%h", q_log[29], enc(p[20]));
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (q !== 10'h000 || busy !== 1'b0 || s_ready !== 1'b0 || frame_cnt !== 16'h0) begin
      errors++; $display("FAIL rst_cut q=%h busy=%b rdy=%b cnt=%h want 000/0/0/0000",
                         q, busy, s_ready, frame_cnt);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_frames = '0;
    @(negedge clk);
    p = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    stim_q.delete(); add_frame(p);
    drive(stim_q, -1, 40);
    f = first_active(0);
    n = 0;
    if (f < 0) n = 1;
    else if ({q_log[f+17], q_log[f+18], q_log[f+19], q_log[f+20]} !==
             {enc(8'h26), enc(8'h39), enc(8'hF4), enc(8'hCB)}) n = 1;
    checks++;
    if (n != 0) begin errors++; $display("FAIL rst_fresh_crc fcs words differ from 26 39 F4 CB"); end
    exp_frames++;
    checks++;
    if (frame_cnt !== exp_frames) begin
      errors++; $display("FAIL rst_frame_cnt got=%h want=%h", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_pad();
    logic [7:0] p[$];
    int f, n;
    stim_q.delete(); add_frame('{8'hAB});
    drive(stim_q, -1, 95);
    p.push_back(8'hAB);
`ifdef RGMII_TX_PAD_EN
    for (int i = 0; i < 59; i++) p.push_back(8'h00);
`endif
    build_exp(p);
    f = first_active(0);
    n = 0;
    if (f < 0) n = 1; else foreach (exp_q[i]) if (q_log[f+i] !== exp_q[i]) n++;
    checks++;
    if (n != 0) begin errors++; $display("FAIL pad_words bad=%0d len=%0d", n, exp_q.size()); end
    checks++;
    if (f < 0 || q_log[f + exp_q.size()] !== 10'h000 || first_done(0) !== f + exp_q.size() - 1) begin
      errors++; $display("FAIL pad_length done=%0d want=%0d", first_done(0), f + exp_q.size() - 1);
    end
    exp_frames++;
    checks++;
    if (frame_cnt !== exp_frames) begin
      errors++; $display("FAIL pad_frame_cnt got=%h want=%h", frame_cnt, exp_frames);
    end
  endtask

  task automatic test_frame_cnt_wrap();
    force dut.frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt;
    @(negedge clk);
    checks++;
    if (frame_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload got=%h want=ffff", frame_cnt);
    end
    stim_q.delete(); add_frame('{8'h01, 8'h02, 8'h03});
    drive(stim_q, -1, 35);
    checks++;
    if (frame_cnt !== 16'h0000 || first_done(0) < 0) begin
      errors++; $display("FAIL wrap_result got=%h done_at=%0d want=0000", frame_cnt, first_done(0));
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_back_to_back();
    test_underrun();
    test_mid_frame_reset();
    test_pad();
    test_frame_cnt_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
